// File: rtl/ctrl_pkg.sv
// Shared control-path types for the five-stage pipeline: opcodes, field
// encodings, per-stage control slices and the halt state enum.
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] HALT   = 7'b1111111;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALU_ADD    = 2'b00;
    localparam alu_op_t ALU_BRANCH = 2'b01;
    localparam alu_op_t ALU_FUNC   = 2'b10;
    localparam alu_op_t ALU_PASS_B = 2'b11;

    typedef logic [1:0] wb_sel_t;
    localparam wb_sel_t WB_ALU = 2'b00;
    localparam wb_sel_t WB_MEM = 2'b01;
    localparam wb_sel_t WB_PC4 = 2'b10;

    typedef logic [1:0] jump_t;
    localparam jump_t JUMP_NONE = 2'b00;
    localparam jump_t JUMP_JAL  = 2'b01;
    localparam jump_t JUMP_JALR = 2'b10;

    localparam int CNT_W = 4;

    // Nested slices so each pipeline register holds only what later stages read.
    typedef struct packed {
        logic    reg_write;
        wb_sel_t wb_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_read;
        logic     mem_write;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    typedef struct packed {
        logic      alu_src;
        alu_op_t   alu_op;
        logic      branch;
        jump_t     jump;
        logic      auipc;
        mem_ctrl_t mem;
    } ex_ctrl_t;

    typedef struct packed {
        ex_ctrl_t ex;
        logic     halt;
        logic     illegal;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_e;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational ID-stage decoder: opcode plus valid into a control bundle.
// ILLEGAL_TRAP_EN turns undefined opcodes into a HALT-like trap.
module opcode_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                id_valid_i,
    output ctrl_bundle_t        bundle_o
);

    always_comb begin
        bundle_o = '0;
        if (id_valid_i) begin
            case (opcode_i)
                R_TYPE: begin
                    bundle_o.ex.mem.wb.reg_write = 1'b1;
                    bundle_o.ex.alu_op           = ALU_FUNC;
                end
                I_TYPE: begin
                    bundle_o.ex.alu_src          = 1'b1;
                    bundle_o.ex.mem.wb.reg_write = 1'b1;
                    bundle_o.ex.alu_op           = ALU_FUNC;
                end
                LW: begin
                    bundle_o.ex.alu_src          = 1'b1;
                    bundle_o.ex.mem.mem_read     = 1'b1;
                    bundle_o.ex.mem.wb.reg_write = 1'b1;
                    bundle_o.ex.mem.wb.wb_sel    = WB_MEM;
                end
                SW: begin
                    bundle_o.ex.alu_src       = 1'b1;
                    bundle_o.ex.mem.mem_write = 1'b1;
                end
                BR: begin
                    bundle_o.ex.branch = 1'b1;
                    bundle_o.ex.alu_op = ALU_BRANCH;
                end
                JAL: begin
                    bundle_o.ex.jump             = JUMP_JAL;
                    bundle_o.ex.mem.wb.reg_write = 1'b1;
                    bundle_o.ex.mem.wb.wb_sel    = WB_PC4;
                end
                JALR: begin
                    bundle_o.ex.jump             = JUMP_JALR;
                    bundle_o.ex.alu_src          = 1'b1;
                    bundle_o.ex.mem.wb.reg_write = 1'b1;
                    bundle_o.ex.mem.wb.wb_sel    = WB_PC4;
                end
                LUI: begin
                    bundle_o.ex.alu_src          = 1'b1;
                    bundle_o.ex.alu_op           = ALU_PASS_B;
                    bundle_o.ex.mem.wb.reg_write = 1'b1;
                end
                AUIPC: begin
                    bundle_o.ex.alu_src          = 1'b1;
                    bundle_o.ex.auipc            = 1'b1;
                    bundle_o.ex.mem.wb.reg_write = 1'b1;
                end
                HALT: bundle_o.halt = 1'b1;
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    bundle_o.halt    = 1'b1;
                    bundle_o.illegal = 1'b1;
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control unit for the five-stage pipeline: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers and a halt drain FSM. Optional macro: ILLEGAL_TRAP_EN.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 7,
    parameter int ALUOP_W      = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                id_valid_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic                ex_alu_src_o,
    output logic [ALUOP_W-1:0]  ex_alu_op_o,
    output logic                ex_branch_o,
    output logic [1:0]          ex_jump_o,
    output logic                ex_auipc_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                wb_reg_write_o,
    output logic [1:0]          wb_sel_o,
    output logic                fetch_en_o,
    output logic                halted_o,
    output logic                illegal_o
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    ctrl_bundle_t      dec;
    ex_ctrl_t          id_ex;
    mem_ctrl_t         ex_mem;
    wb_ctrl_t          mem_wb;
    halt_state_e       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              halt_accept;

    opcode_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
        .opcode_i   (opcode_i),
        .id_valid_i (id_valid_i),
        .bundle_o   (dec)
    );

    // Flush outranks stall; either one turns the ID/EX slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset)                id_ex <= '0;
        else if (flush_i || stall_i) id_ex <= '0;
        else                      id_ex <= dec.ex;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            ex_mem <= id_ex.mem;
            mem_wb <= ex_mem.wb;
        end
    end

    assign halt_accept = dec.halt && !flush_i && !stall_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (halt_accept) begin
                    state_next = DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt == '0) state_next = HALTED;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Fetch stops combinationally on a HALT in ID so nothing younger is fetched.
    always_comb begin
        fetch_en_o = 1'b0;
        halted_o   = 1'b0;
        case (state)
            RUN:     fetch_en_o = !stall_i && !dec.halt;
            HALTED:  halted_o   = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (reset)                                             illegal_q <= 1'b0;
        else if (state == RUN && halt_accept && dec.illegal)   illegal_q <= 1'b1;
    end
    assign illegal_o = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = dec.illegal;
    assign illegal_o      = 1'b0;
`endif

    assign ex_alu_src_o   = id_ex.alu_src;
    assign ex_alu_op_o    = id_ex.alu_op;
    assign ex_branch_o    = id_ex.branch;
    assign ex_jump_o      = id_ex.jump;
    assign ex_auipc_o     = id_ex.auipc;
    assign mem_read_o     = ex_mem.mem_read;
    assign mem_write_o    = ex_mem.mem_write;
    assign wb_reg_write_o = mem_wb.reg_write;
    assign wb_sel_o       = mem_wb.wb_sel;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control unit for the five-stage RISC-V pipeline.
- Decodes the opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, each stage exposing its own control slice.
- Supports stall, flush, an extended opcode set (JAL, JALR, LUI, AUIPC) and a halt drain state machine that stops fetch and signals when the pipeline is empty.

Parameters:
- OPCODE_W, 7, opcode field width.
- ALUOP_W, 2, ALUOp width (00 LW/SW/JAL/JALR/AUIPC add, 01 branch, 10 R/I-type, 11 LUI pass-B).
- DRAIN_CYCLES, 3, cycles after HALT enters EX before halted_o asserts; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- opcode_i  in  OPCODE_W  opcode of the instruction in ID
- id_valid_i  in  1  the instruction in ID is valid
- stall_i  in  1  load-use hazard: hold ID, insert a bubble into EX
- flush_i  in  1  taken branch or jump resolved in EX: kill the instruction in ID
- ex_alu_src_o  out  1  ALU operand B is the immediate
- ex_alu_op_o  out  ALUOP_W  ALU operation class
- ex_branch_o  out  1  conditional branch in EX
- ex_jump_o  out  2  00 none, 01 JAL, 10 JALR
- ex_auipc_o  out  1  ALU operand A is the PC
- mem_read_o  out  1  load in MEM
- mem_write_o  out  1  store in MEM
- wb_reg_write_o  out  1  register file write in WB
- wb_sel_o  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4
- fetch_en_o  out  1  IF may advance the PC
- halted_o  out  1  pipeline drained after HALT; sticky
- illegal_o  out  1  see Optional Feature

Behaviour:
- Decode (combinational, ID):
  - R 0110011: RegWrite, ALUOp 10.
  - I 0010011: ALUSrc, RegWrite, ALUOp 10.
  - LW 0000011: ALUSrc, MemRead, RegWrite, wb_sel 01.
  - SW 0100011: ALUSrc, MemWrite.
  - BR 1100011: Branch, ALUOp 01.
  - JAL 1101111: jump 01, RegWrite, wb_sel 10.
  - JALR 1100111: jump 10, ALUSrc, RegWrite, wb_sel 10.
  - LUI 0110111: ALUSrc, ALUOp 11, RegWrite.
  - AUIPC 0010111: ALUSrc, auipc, RegWrite.
  - HALT 1111111: halt flag only.
  - Any other opcode, or id_valid_i=0: all-zero bubble.
- ID/EX register, evaluated every clk edge in this priority order:
  - reset → bubble;
  - flush_i → bubble;
  - stall_i → bubble;
  - otherwise → load the decoded bundle.
- EX/MEM and MEM/WB registers always advance, never stall, and are cleared only by reset.
- Latency: opcode to ex_* is 1 cycle, to mem_* 2 cycles, to wb_* 3 cycles.
- Simultaneous flush_i and stall_i: flush wins, giving a bubble; the stall has no effect on ID/EX.
- Halt state machine, states RUN, DRAIN, HALTED:
  - RUN → DRAIN when a HALT bundle is loaded into ID/EX, i.e. HALT decoded, valid, not flushed, not stalled. The counter loads DRAIN_CYCLES-1.
  - DRAIN: the counter decrements each cycle; at 0 the state moves to HALTED.
  - HALTED persists until reset.
- fetch_en_o = 1 only in RUN and only when stall_i=0. It goes to 0 in the same cycle a HALT is present in ID, so nothing younger than the HALT is fetched.
- halted_o = 1 only in HALTED.
- A HALT in ID that is flushed leaves the state at RUN.
- flush_i and stall_i during DRAIN have no effect on the state machine.
- Reset in any state (mid-drain included): RUN, counter 0, all pipeline registers bubble, fetch_en_o=1, halted_o=0, illegal_o=0. The cycle after reset deasserts, all outputs are 0 except fetch_en_o=1.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an undefined opcode with id_valid_i=1 that is accepted into ID/EX (same rule as HALT) acts exactly as HALT, entering DRAIN. illegal_o sets in the same cycle and is sticky until reset.
- Not defined: an undefined opcode becomes a bubble and illegal_o is tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, LUI, AUIPC, HALT);
  - ALUOp and wb_sel encodings;
  - packed struct ctrl_bundle_t holding all decoded fields plus halt;
  - enum halt_state_e {RUN, DRAIN, HALTED}.
- Sub-module opcode_decoder: purely combinational, opcode_i/id_valid_i to ctrl_bundle_t.

Test Plan:
- LW then SW then R, one per cycle, no stall → ex_alu_src=1,1,0; mem_read=1 at cycle 2; mem_write=1 at cycle 3; wb_reg_write=1 at cycles 3 and 5; wb_sel=01 at cycle 3.
- LW in ID with stall_i=1 for 1 cycle → next cycle all ex_* outputs = 0; LW appears in EX one cycle later; fetch_en_o=0 during the stall.
- BR in EX, JAL in ID, flush_i=1 → JAL never reaches EX; wb_reg_write never 1 for it.
- HALT accepted with DRAIN_CYCLES=3 → fetch_en_o=0 from the HALT-in-ID cycle; halted_o rises exactly 3 cycles after HALT enters EX; reset mid-DRAIN → halted_o=0, fetch_en_o=1.
- HALT in ID with flush_i=1 and stall_i=1 together → state stays RUN, ID/EX is a bubble.
- Opcode 7'b0001011 valid → with ILLEGAL_TRAP_EN: illegal_o=1 next cycle, then halted_o after DRAIN_CYCLES; without it: bubble only, illegal_o=0.
